// File: rtl/commit_trace_unit_if.sv
// Retire-trace stream between commit_trace_unit and a trace consumer.
// Master drives the record and valid; slave returns ready.
interface commit_trace_unit_if;
  logic        tr_valid_o;
  logic        tr_ready_i;
  logic [31:0] tr_pc_o;
  logic [31:0] tr_inst_o;
  logic        tr_rd_we_o;
  logic [4:0]  tr_rd_addr_o;
  logic [31:0] tr_rd_data_o;

  modport master (
    output tr_valid_o, tr_pc_o, tr_inst_o,
    output tr_rd_we_o, tr_rd_addr_o, tr_rd_data_o,
    input  tr_ready_i
  );

  modport slave (
    input  tr_valid_o, tr_pc_o, tr_inst_o,
    input  tr_rd_we_o, tr_rd_addr_o, tr_rd_data_o,
    output tr_ready_i
  );
endinterface

// File: rtl/commit_trace_unit.sv
// Shadows ID->EX->MEM->WB and emits one commit record per retired
// instruction into a first-word fall-through FIFO.
module commit_trace_unit #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 id_valid_i,
  input  logic [31:0]          id_pc_i,
  input  logic [31:0]          id_inst_i,
  input  logic                 stall_i,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_addr_i,
  input  logic [31:0]          wb_data_i,
  commit_trace_unit_if.master  tr,
  output logic                 overflow_o,
  output logic [CNT_W-1:0]     drop_cnt_o,
  output logic [31:0]          retire_cnt_o,
  output logic                 halt_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
  } slot_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } rec_t;

  slot_t         ex_q, mem_q, wb_q;
  rec_t          fifo_q [DEPTH];
  rec_t          rec, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          full, commit, pop, push, drop, rd_we;

  assign full   = cnt == (AW+1)'(DEPTH);
  assign commit = wb_q.v && !halt_o;
  assign pop    = (cnt != '0) && tr.tr_ready_i;
  assign push   = commit && (!full || pop);
  assign drop   = commit && full && !pop;
  assign rd_we  = wb_we_i && (wb_addr_i != 5'd0);

  // x0 writes are architecturally void, so they trace as no write
  assign rec.pc   = wb_q.pc;
  assign rec.inst = wb_q.inst;
  assign rec.we   = rd_we;
  assign rec.addr = rd_we ? wb_addr_i : 5'd0;
  assign rec.data = rd_we ? wb_data_i : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= stall_i ? '0 : slot_t'{id_valid_i, id_pc_i, id_inst_i};
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr] <= rec;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o   <= 1'b0;
      drop_cnt_o   <= '0;
      retire_cnt_o <= '0;
      halt_o       <= 1'b0;
    end else begin
      if (commit) retire_cnt_o <= retire_cnt_o + 32'd1;
      if (drop) overflow_o <= 1'b1;
      if (drop && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      if (commit && wb_q.inst == 32'd0) halt_o <= 1'b1;
    end
  end

  assign head             = fifo_q[rd_ptr];
  assign tr.tr_valid_o    = cnt != '0;
  assign tr.tr_pc_o       = head.pc;
  assign tr.tr_inst_o     = head.inst;
  assign tr.tr_rd_we_o    = head.we;
  assign tr.tr_rd_addr_o  = head.addr;
  assign tr.tr_rd_data_o  = head.data;
endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed bench for commit_trace_unit: latency, stall, overflow,
// full-with-pop, halt and mid-stream reset.
module tb_commit_trace_unit;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [31:0] id_pc_i;
  logic [31:0] id_inst_i;
  logic        stall_i;
  logic        wb_we_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;
  logic [31:0] retire_cnt_o;
  logic        halt_o;
  int          ntests = 0;
  int          nfail  = 0;

  commit_trace_unit_if tr();

  commit_trace_unit #(.DEPTH(8), .CNT_W(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .id_valid_i   (id_valid_i),
    .id_pc_i      (id_pc_i),
    .id_inst_i    (id_inst_i),
    .stall_i      (stall_i),
    .wb_we_i      (wb_we_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .tr           (tr),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o),
    .retire_cnt_o (retire_cnt_o),
    .halt_o       (halt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    id_valid_i = 1'b0;
    id_pc_i    = 32'd0;
    id_inst_i  = 32'd0;
    stall_i    = 1'b0;
    wb_we_i    = 1'b0;
    wb_addr_i  = 5'd0;
    wb_data_i  = 32'd0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    tr.tr_ready_i = 1'b0;
    id_valid_i = 1'b1;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    idle_in();
    ntests++;
    if (tr.tr_valid_o !== 1'b0) begin
      nfail++; $display("FAIL rst_valid got %b want 0", tr.tr_valid_o);
    end
    ntests++;
    if ({overflow_o, halt_o} !== 2'b00) begin
      nfail++; $display("FAIL rst_flags got %b want 00", {overflow_o, halt_o});
    end
    ntests++;
    if (drop_cnt_o !== 16'd0 || retire_cnt_o !== 32'd0) begin
      nfail++; $display("FAIL rst_cnts got %0d/%0d want 0/0", drop_cnt_o, retire_cnt_o);
    end
  endtask

  task automatic test_latency();
    tr.tr_ready_i = 1'b1;
    id_valid_i = 1'b1;
    id_pc_i    = 32'h0001_0008;
    id_inst_i  = 32'h0050_0093;
    step();
    id_valid_i = 1'b0;
    for (int c = 1; c < 4; c++) begin
      if (c == 3) begin
        wb_we_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 32'd5;
      end
      ntests++;
      if (tr.tr_valid_o !== 1'b0) begin
        nfail++; $display("FAIL lat_early c%0d got %b want 0", c, tr.tr_valid_o);
      end
      step();
    end
    idle_in();
    ntests++;
    if ({tr.tr_valid_o, tr.tr_pc_o, tr.tr_inst_o, tr.tr_rd_we_o,
         tr.tr_rd_addr_o, tr.tr_rd_data_o} !==
        {1'b1, 32'h0001_0008, 32'h0050_0093, 1'b1, 5'd1, 32'd5}) begin
      nfail++;
      $display("FAIL lat_rec got v%b %h %h %b %0d %0d want v1 00010008 00500093 1 1 5",
               tr.tr_valid_o, tr.tr_pc_o, tr.tr_inst_o, tr.tr_rd_we_o,
               tr.tr_rd_addr_o, tr.tr_rd_data_o);
    end
    ntests++;
    if (retire_cnt_o !== 32'd1) begin
      nfail++; $display("FAIL lat_retire got %0d want 1", retire_cnt_o);
    end
    step();
    ntests++;
    if (tr.tr_valid_o !== 1'b0) begin
      nfail++; $display("FAIL lat_after got %b want 0", tr.tr_valid_o);
    end
  endtask

  task automatic test_stall_x0();
    tr.tr_ready_i = 1'b1;
    id_valid_i = 1'b1;
    id_pc_i    = 32'h0000_0100;
    id_inst_i  = 32'h0000_0013;
    stall_i    = 1'b1;
    step();
    stall_i = 1'b0;
    step();
    id_valid_i = 1'b0;
    for (int c = 2; c < 5; c++) begin
      if (c == 4) begin
        wb_we_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hDEAD;
      end
      ntests++;
      if (tr.tr_valid_o !== 1'b0) begin
        nfail++; $display("FAIL stall_early c%0d got %b want 0", c, tr.tr_valid_o);
      end
      step();
    end
    idle_in();
    ntests++;
    if ({tr.tr_valid_o, tr.tr_pc_o, tr.tr_rd_we_o, tr.tr_rd_addr_o,
         tr.tr_rd_data_o} !== {1'b1, 32'h100, 1'b0, 5'd0, 32'd0}) begin
      nfail++;
      $display("FAIL stall_rec got v%b %h %b %0d %h want v1 00000100 0 0 0",
               tr.tr_valid_o, tr.tr_pc_o, tr.tr_rd_we_o, tr.tr_rd_addr_o,
               tr.tr_rd_data_o);
    end
    ntests++;
    if (retire_cnt_o !== 32'd2) begin
      nfail++; $display("FAIL stall_retire got %0d want 2", retire_cnt_o);
    end
    step();
    ntests++;
    if (tr.tr_valid_o !== 1'b0) begin
      nfail++; $display("FAIL stall_single got %b want 0", tr.tr_valid_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    tr.tr_ready_i = 1'b0;
    for (int c = 0; c < 13; c++) begin
      id_valid_i = (c < 10);
      id_pc_i    = 32'(32'h200 + 4 * c);
      id_inst_i  = 32'(32'h1000_0013 + c);
      wb_we_i    = (c >= 3);
      wb_addr_i  = 5'(c - 2);
      wb_data_i  = 32'(32'hA0 + c - 3);
      step();
    end
    idle_in();
    ntests++;
    if ({overflow_o, drop_cnt_o} !== {1'b1, 16'd2}) begin
      nfail++; $display("FAIL ovf_flags got %b/%0d want 1/2", overflow_o, drop_cnt_o);
    end
    ntests++;
    if (retire_cnt_o !== 32'd10) begin
      nfail++; $display("FAIL ovf_retire got %0d want 10", retire_cnt_o);
    end
    tr.tr_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ntests++;
      if ({tr.tr_valid_o, tr.tr_pc_o, tr.tr_inst_o, tr.tr_rd_we_o,
           tr.tr_rd_addr_o, tr.tr_rd_data_o} !==
          {1'b1, 32'(32'h200 + 4 * k), 32'(32'h1000_0013 + k), 1'b1,
           5'(k + 1), 32'(32'hA0 + k)}) begin
        nfail++;
        $display("FAIL ovf_drain k%0d got v%b pc %h inst %h rd %0d data %h",
                 k, tr.tr_valid_o, tr.tr_pc_o, tr.tr_inst_o,
                 tr.tr_rd_addr_o, tr.tr_rd_data_o);
      end
      step();
    end
    ntests++;
    if (tr.tr_valid_o !== 1'b0) begin
      nfail++; $display("FAIL ovf_empty got %b want 0", tr.tr_valid_o);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    tr.tr_ready_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      id_valid_i    = (c < 9);
      id_pc_i       = 32'(32'h300 + 4 * c);
      id_inst_i     = 32'(32'h2000_0013 + c);
      wb_we_i       = (c >= 3);
      wb_addr_i     = 5'(c);
      wb_data_i     = 32'(c);
      tr.tr_ready_i = (c == 11);
      if (c == 11) begin
        ntests++;
        if ({tr.tr_valid_o, tr.tr_pc_o} !== {1'b1, 32'h300}) begin
          nfail++; $display("FAIL fp_head got v%b %h want v1 00000300", tr.tr_valid_o, tr.tr_pc_o);
        end
      end
      step();
    end
    idle_in();
    tr.tr_ready_i = 1'b0;
    ntests++;
    if ({overflow_o, drop_cnt_o, retire_cnt_o} !== {1'b0, 16'd0, 32'd9}) begin
      nfail++;
      $display("FAIL fp_cnts got %b/%0d/%0d want 0/0/9", overflow_o, drop_cnt_o, retire_cnt_o);
    end
    tr.tr_ready_i = 1'b1;
    for (int k = 1; k < 9; k++) begin
      ntests++;
      if ({tr.tr_valid_o, tr.tr_pc_o, tr.tr_rd_addr_o} !==
          {1'b1, 32'(32'h300 + 4 * k), 5'(k + 3)}) begin
        nfail++;
        $display("FAIL fp_drain k%0d got v%b %h rd %0d", k, tr.tr_valid_o,
                 tr.tr_pc_o, tr.tr_rd_addr_o);
      end
      step();
    end
    ntests++;
    if (tr.tr_valid_o !== 1'b0) begin
      nfail++; $display("FAIL fp_empty got %b want 0", tr.tr_valid_o);
    end
  endtask

  task automatic test_halt();
    do_reset();
    tr.tr_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      id_valid_i = 1'b1;
      id_pc_i    = 32'(32'h400 + 4 * c);
      id_inst_i  = (c == 0) ? 32'd0 : 32'(32'h13 + c);
      if (c == 3) begin
        ntests++;
        if (halt_o !== 1'b0) begin
          nfail++; $display("FAIL halt_early got %b want 0", halt_o);
        end
      end
      step();
    end
    idle_in();
    ntests++;
    if ({tr.tr_valid_o, tr.tr_pc_o, tr.tr_inst_o, halt_o, retire_cnt_o} !==
        {1'b1, 32'h400, 32'd0, 1'b1, 32'd1}) begin
      nfail++;
      $display("FAIL halt_rec got v%b %h %h h%b r%0d want v1 00000400 0 h1 r1",
               tr.tr_valid_o, tr.tr_pc_o, tr.tr_inst_o, halt_o, retire_cnt_o);
    end
    for (int c = 5; c < 9; c++) begin
      step();
      ntests++;
      if ({tr.tr_valid_o, halt_o, retire_cnt_o} !== {1'b0, 1'b1, 32'd1}) begin
        nfail++;
        $display("FAIL halt_frozen c%0d got v%b h%b r%0d want v0 h1 r1",
                 c, tr.tr_valid_o, halt_o, retire_cnt_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tr.tr_ready_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      id_valid_i = (c < 5);
      id_pc_i    = 32'(32'h500 + 4 * c);
      id_inst_i  = 32'(32'h3000_0013 + c);
      step();
    end
    idle_in();
    ntests++;
    if ({tr.tr_valid_o, retire_cnt_o} !== {1'b1, 32'd5}) begin
      nfail++; $display("FAIL rm_pre got v%b r%0d want v1 r5", tr.tr_valid_o, retire_cnt_o);
    end
    id_valid_i = 1'b1;
    id_pc_i    = 32'h5F0;
    id_inst_i  = 32'h33;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    ntests++;
    if ({tr.tr_valid_o, overflow_o, halt_o, drop_cnt_o, retire_cnt_o} !== '0) begin
      nfail++;
      $display("FAIL rm_clear got v%b o%b h%b d%0d r%0d want all 0", tr.tr_valid_o,
               overflow_o, halt_o, drop_cnt_o, retire_cnt_o);
    end
    id_pc_i   = 32'h600;
    id_inst_i = 32'h0020_0113;
    tr.tr_ready_i = 1'b1;
    step();
    idle_in();
    for (int c = 10; c < 13; c++) begin
      ntests++;
      if (tr.tr_valid_o !== 1'b0) begin
        nfail++; $display("FAIL rm_early c%0d got %b want 0", c, tr.tr_valid_o);
      end
      step();
    end
    ntests++;
    if ({tr.tr_valid_o, tr.tr_pc_o, tr.tr_inst_o, retire_cnt_o} !==
        {1'b1, 32'h600, 32'h0020_0113, 32'd1}) begin
      nfail++;
      $display("FAIL rm_new got v%b %h %h r%0d want v1 00000600 00200113 r1",
               tr.tr_valid_o, tr.tr_pc_o, tr.tr_inst_o, retire_cnt_o);
    end
  endtask

  initial begin
    rst_i = 1'b0;
    tr.tr_ready_i = 1'b0;
    idle_in();
    #2;
    test_reset();
    test_latency();
    test_stall_x0();
    test_overflow();
    test_full_pop();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
